uart_rx_frame: RTL and testbench
================================

# uart_rx_frame

Receive-side framer for the UART: samples the serial line with a 16x oversampling tick and recovers frames of start bit, 8 data bits (LSB first), optional parity bit and stop bit. It checks the parity bit with the same parity_type encoding the transmit-side parity generator uses, and checks the stop bit. Each completed frame is presented as a parallel byte with a one-cycle valid strobe and error flags. It sits between the rx pin and the receive FIFO/host logic, mirroring the transmit path.

## Interface
- OVERSAMPLE, 16: baud_tick pulses per bit period; even, at least 4.
- DATA_BITS, 8: data bits per frame.
- clock  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- baud_tick  input  1  one-clock enable pulse at OVERSAMPLE x baud rate.
- rx_in  input  1  serial line; asynchronous to clock; idles high.
- parity_type  input  2  00 and 11 = no parity bit; 01 = odd; 10 = even.
- data_out  output  DATA_BITS  last received byte.
- data_valid  output  1  one-clock pulse when a frame completes.
- parity_error  output  1  parity mismatch on the last frame; 0 when parity is disabled.
- stop_error  output  1  stop bit sampled 0 on the last frame.
- busy  output  1  high from start detection until the frame completes.

## Operation
- rx_in passes through a 2-flop synchronizer (rx_s). Both flops reset to 1. All decisions use rx_s.
- A tick counter (log2(OVERSAMPLE) bits) and a bit counter (log2(DATA_BITS)+1 bits) advance only on baud_tick.
- IDLE: armed only after rx_s has been sampled 1 on at least one tick since entering IDLE. While armed, rx_s = 0 on a tick → START, tick counter cleared, parity_type latched (later changes ignored until the next frame), busy = 1.
- START: at the OVERSAMPLE/2-th tick after detection, sample rx_s.
  - 1 → false start: return to IDLE, no output change.
  - 0 → DATA, tick counter cleared.
- DATA: every OVERSAMPLE ticks, sample rx_s and shift it in LSB first. After DATA_BITS samples:
  - latched parity enabled → PARITY.
  - otherwise → STOP.
- PARITY: sample after OVERSAMPLE ticks.
  - odd: error if data ones + parity bit is even.
  - even: error if that count is odd.
- STOP: sample after OVERSAMPLE ticks.
  - In the same clock: data_out ← shift register, parity_error and stop_error registered, data_valid = 1 on the next cycle, busy = 0, return to IDLE (disarmed).
- Flags and data_out hold until the next completed frame. A frame with errors still pulses data_valid.
- A break (line held low) produces one frame with data_out = 0 and stop_error = 1. No further frames are produced until rx_s returns high.
- baud_tick low freezes all counters and the FSM.

## Timing
- Reset values: data_out = 0, data_valid = 0, parity_error = 0, stop_error = 0, busy = 0. FSM in IDLE, disarmed. Synchronizer flops = 1.
- Reset asserted mid-frame aborts immediately. No data_valid is produced, and prior data_out/flags are cleared.
- Start-detect latency is 2 clocks of synchronizer plus the next tick.
- Samples fall at bit centres (OVERSAMPLE/2 ticks after the falling edge, then every OVERSAMPLE ticks).
- data_valid rises in the first clock after the stop-bit sampling tick and lasts exactly one clock, regardless of the baud_tick spacing.
- The next start bit is detected as soon as 1 tick at rx_s = 1 is seen after the mid-stop sample. Back-to-back frames lose no bits.
- If baud_tick and a rx_s falling edge coincide in IDLE while armed, that tick counts as tick 0 of START.

## Test plan
- Odd parity, data 0x17 (4 ones), parity bit 1, stop 1 → data_out = 0x17, one data_valid pulse, parity_error = 0, stop_error = 0, busy high for 10.5 bit times.
- Even parity, data 0xA5, parity bit sent as 1 (wrong) → data_out = 0xA5, data_valid pulse, parity_error = 1. Then send 0x0F with parity bit 0 → parity_error clears to 0.
- Glitch: parity_type = 00, rx_in low for 4 ticks, then high → no data_valid, busy returns 0 after the start sample, and a subsequent clean frame 0x3C is received correctly.
- Break: rx_in held low for 3 frame times, then released → exactly one data_valid with data_out = 0x00 and stop_error = 1. No second frame before release; the next frame 0x81 is received correctly.
- Back-to-back frames 0x55, 0xAA, 0xFF (parity 00, no idle gap) → three data_valid pulses with matching data_out and no errors. Changing parity_type mid-frame has no effect on the current frame.
- Reset_n pulsed low during DATA of frame 0xC3 → all outputs 0 immediately, no data_valid. The receiver re-arms and receives the next frame 0x99 correctly.

Source files
------------

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receive framer with oversampled bit-centre sampling, optional odd/even
// parity and stop-bit checking. Each completed frame yields a byte, a one-clock valid and flags.
module uart_rx_frame #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    input  logic [1:0]           parity_type,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_error,
    output logic                 stop_error,
    output logic                 busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS) + 1;

    localparam logic [TICK_W-1:0] TICK_ZERO  = TICK_W'(0);
    localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_HALF  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_ZERO   = BIT_W'(0);
    localparam logic [BIT_W-1:0]  BIT_ONE    = BIT_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Returns 1 when the received parity bit disagrees with the selected parity mode.
    function automatic logic f_parity_err(
        input logic [DATA_BITS-1:0] data,
        input logic                 pbit,
        input logic [1:0]           ptype
    );
        logic ones_odd;
        ones_odd = (^data) ^ pbit;
        case (ptype)
            2'b01:   f_parity_err = ~ones_odd;
            2'b10:   f_parity_err = ones_odd;
            default: f_parity_err = 1'b0;
        endcase
    endfunction

    function automatic logic f_parity_en(input logic [1:0] ptype);
        f_parity_en = (ptype == 2'b01) || (ptype == 2'b10);
    endfunction

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   w_rx_s;
    logic                   r_armed;
    logic                   w_armed_nxt;
    logic [TICK_W-1:0]      r_tick_cnt;
    logic [TICK_W-1:0]      w_tick_nxt;
    logic [BIT_W-1:0]       r_bit_cnt;
    logic [BIT_W-1:0]       w_bit_nxt;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shift_nxt;
    logic [1:0]             r_ptype;
    logic [1:0]             w_ptype_nxt;
    logic                   r_perr_pend;
    logic                   w_perr_nxt;
    logic                   w_frame_done;
    logic                   w_stop_bad;

    logic [DATA_BITS-1:0]   r_data_out;
    logic                   r_data_valid;
    logic                   r_parity_error;
    logic                   r_stop_error;
    logic                   r_busy;

    assign w_rx_s       = r_sync2;
    assign data_out     = r_data_out;
    assign data_valid   = r_data_valid;
    assign parity_error = r_parity_error;
    assign stop_error   = r_stop_error;
    assign busy         = r_busy;

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath updates; everything advances only on baud_tick.
    always_comb begin
        w_state_nxt  = r_state;
        w_armed_nxt  = r_armed;
        w_tick_nxt   = r_tick_cnt;
        w_bit_nxt    = r_bit_cnt;
        w_shift_nxt  = r_shift;
        w_ptype_nxt  = r_ptype;
        w_perr_nxt   = r_perr_pend;
        w_frame_done = 1'b0;
        w_stop_bad   = 1'b0;
        if (baud_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_armed) begin
                        w_armed_nxt = w_rx_s;
                    end else if (!w_rx_s) begin
                        // The detecting tick is tick 0 of the start bit.
                        w_state_nxt = ST_START;
                        w_armed_nxt = 1'b0;
                        w_tick_nxt  = TICK_ZERO;
                        w_ptype_nxt = parity_type;
                        w_perr_nxt  = 1'b0;
                    end else begin
                        w_armed_nxt = 1'b1;
                    end
                end
                ST_START: begin
                    if (r_tick_cnt == TICK_HALF) begin
                        w_tick_nxt = TICK_ZERO;
                        w_bit_nxt  = BIT_ZERO;
                        if (w_rx_s) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_DATA;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + TICK_ONE;
                    end
                end
                ST_DATA: begin
                    if (r_tick_cnt == TICK_LAST) begin
                        w_tick_nxt  = TICK_ZERO;
                        w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == BIT_LAST) begin
                            w_bit_nxt = BIT_ZERO;
                            if (f_parity_en(r_ptype)) begin
                                w_state_nxt = ST_PARITY;
                            end else begin
                                w_state_nxt = ST_STOP;
                            end
                        end else begin
                            w_bit_nxt = r_bit_cnt + BIT_ONE;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + TICK_ONE;
                    end
                end
                ST_PARITY: begin
                    if (r_tick_cnt == TICK_LAST) begin
                        w_tick_nxt  = TICK_ZERO;
                        w_perr_nxt  = f_parity_err(r_shift, w_rx_s, r_ptype);
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_tick_nxt = r_tick_cnt + TICK_ONE;
                    end
                end
                ST_STOP: begin
                    if (r_tick_cnt == TICK_LAST) begin
                        // Re-arming needs a high sample, so a held break yields a single frame.
                        w_tick_nxt   = TICK_ZERO;
                        w_frame_done = 1'b1;
                        w_stop_bad   = ~w_rx_s;
                        w_armed_nxt  = 1'b0;
                        w_state_nxt  = ST_IDLE;
                    end else begin
                        w_tick_nxt = r_tick_cnt + TICK_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_armed_nxt = 1'b0;
                    w_tick_nxt  = TICK_ZERO;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Datapath registers: counters, shift register, latched parity mode and pending parity flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_armed     <= 1'b0;
            r_tick_cnt  <= TICK_ZERO;
            r_bit_cnt   <= BIT_ZERO;
            r_shift     <= {DATA_BITS{1'b0}};
            r_ptype     <= 2'b00;
            r_perr_pend <= 1'b0;
        end else begin
            r_armed     <= w_armed_nxt;
            r_tick_cnt  <= w_tick_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_ptype     <= w_ptype_nxt;
            r_perr_pend <= w_perr_nxt;
        end
    end

    // Output registers: byte and flags update only on frame completion; valid is a single clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out     <= {DATA_BITS{1'b0}};
            r_data_valid   <= 1'b0;
            r_parity_error <= 1'b0;
            r_stop_error   <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            if (w_frame_done) begin
                r_data_out     <= r_shift;
                r_data_valid   <= 1'b1;
                r_parity_error <= r_perr_pend;
                r_stop_error   <= w_stop_bad;
            end else begin
                r_data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed testbench for uart_rx_frame: serial frames are driven bit by bit and the
// received byte, strobe count and flags are compared against hand-computed values.
module tb_uart_rx_frame;

    localparam int OS     = 16;
    localparam int TDIV   = 2;
    localparam int BITCLK = OS * TDIV;

    logic       clock;
    logic       reset_n;
    logic       baud_tick;
    logic       rx_in;
    logic [1:0] parity_type;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;
    logic       busy;

    int n_total;
    int n_bad;
    int vcount;
    int busy_cnt;
    logic [9:0] cap_q[$];

    uart_rx_frame #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .baud_tick    (baud_tick),
        .rx_in        (rx_in),
        .parity_type  (parity_type),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Baud tick: one clock in every TDIV, changed on the falling edge.
    initial begin
        int cnt;
        cnt = 0;
        baud_tick = 1'b0;
        forever begin
            @(negedge clock);
            baud_tick = (cnt == 0);
            cnt = (cnt + 1) % TDIV;
        end
    end

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (data_valid) begin
            vcount = vcount + 1;
            cap_q.push_back({parity_error, stop_error, data_out});
        end
        if (busy) busy_cnt = busy_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (BITCLK) @(negedge clock);
    endtask

    task automatic idle_bits(input int n);
        rx_in = 1'b1;
        repeat (n * BITCLK) @(negedge clock);
    endtask

    // Start, 8 data bits LSB first, optional parity bit, stop bit.
    // With flip_pt set, parity_type is disturbed during the data bits and restored before the stop bit.
    task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                              input logic stopb, input logic flip_pt);
        logic [1:0] saved;
        saved = parity_type;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (flip_pt && i == 3) parity_type = 2'b01;
            if (flip_pt && i == 7) parity_type = saved;
            send_bit(d[i]);
        end
        if (has_par) send_bit(pbit);
        send_bit(stopb);
    endtask

    task automatic check_last(input string tag, input int exp_count, input logic [7:0] exp_d,
                              input logic exp_pe, input logic exp_se);
        logic [9:0] c;
        check_eq({tag, "_count"}, 32'(vcount), 32'(exp_count));
        c = (cap_q.size() > 0) ? cap_q[cap_q.size()-1] : 10'h3FF;
        check_eq({tag, "_data"}, 32'(c[7:0]), 32'(exp_d));
        check_eq({tag, "_perr"}, 32'(c[9]), 32'(exp_pe));
        check_eq({tag, "_serr"}, 32'(c[8]), 32'(exp_se));
    endtask

    initial begin
        int base;
        n_total = 0;
        n_bad = 0;
        vcount = 0;
        busy_cnt = 0;
        reset_n = 1'b0;
        rx_in = 1'b1;
        parity_type = 2'b00;
        repeat (5) @(negedge clock);
        check_eq("rst_data",  32'(data_out), 32'h0);
        check_eq("rst_valid", 32'(data_valid), 32'h0);
        check_eq("rst_perr",  32'(parity_error), 32'h0);
        check_eq("rst_serr",  32'(stop_error), 32'h0);
        check_eq("rst_busy",  32'(busy), 32'h0);
        reset_n = 1'b1;
        idle_bits(2);

        // Odd parity, 0x17 has four ones, parity bit 1 -> clean frame.
        parity_type = 2'b01;
        busy_cnt = 0;
        send_frame(8'h17, 1'b1, 1'b1, 1'b1, 1'b0);
        idle_bits(1);
        check_last("odd17", 1, 8'h17, 1'b0, 1'b0);
        check_eq("odd17_busylen", 32'(busy_cnt >= 10 * BITCLK + 10 && busy_cnt <= 10 * BITCLK + 20), 32'h1);

        // Even parity, 0xA5 with wrong parity bit, then 0x0F with correct one.
        parity_type = 2'b10;
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
        idle_bits(1);
        check_last("evenA5", 2, 8'hA5, 1'b1, 1'b0);
        check_eq("evenA5_flag_hold", 32'(parity_error), 32'h1);
        send_frame(8'h0F, 1'b1, 1'b0, 1'b1, 1'b0);
        idle_bits(1);
        check_last("even0F", 3, 8'h0F, 1'b0, 1'b0);

        // Glitch shorter than half a bit is rejected as a false start.
        parity_type = 2'b00;
        rx_in = 1'b0;
        repeat (4 * TDIV) @(negedge clock);
        check_eq("glitch_busy_hi", 32'(busy), 32'h1);
        rx_in = 1'b1;
        idle_bits(1);
        check_eq("glitch_busy_lo", 32'(busy), 32'h0);
        check_eq("glitch_novalid", 32'(vcount), 32'd3);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_bits(1);
        check_last("nopar3C", 4, 8'h3C, 1'b0, 1'b0);

        // Break: line low for three frame times yields one zero frame with stop error.
        rx_in = 1'b0;
        repeat (30 * BITCLK) @(negedge clock);
        check_last("break", 5, 8'h00, 1'b0, 1'b1);
        idle_bits(2);
        check_eq("break_release_count", 32'(vcount), 32'd5);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_bits(1);
        check_last("after_break81", 6, 8'h81, 1'b0, 1'b0);

        // Back-to-back frames with no idle gap; parity_type disturbed in the middle frame.
        base = cap_q.size();
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_bits(1);
        check_eq("b2b_count", 32'(vcount), 32'd9);
        check_eq("b2b_0", 32'((cap_q.size() > base)     ? cap_q[base]     : 10'h3FF), 32'h055);
        check_eq("b2b_1", 32'((cap_q.size() > base + 1) ? cap_q[base + 1] : 10'h3FF), 32'h0AA);
        check_eq("b2b_2", 32'((cap_q.size() > base + 2) ? cap_q[base + 2] : 10'h3FF), 32'h0FF);

        // Reset during the data bits of 0xC3 (LSB-first 1,1,0,0,...).
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        reset_n = 1'b0;
        rx_in = 1'b1;
        #1;
        check_eq("midrst_data",  32'(data_out), 32'h0);
        check_eq("midrst_valid", 32'(data_valid), 32'h0);
        check_eq("midrst_busy",  32'(busy), 32'h0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        idle_bits(2);
        check_eq("midrst_novalid", 32'(vcount), 32'd9);
        send_frame(8'h99, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_bits(1);
        check_last("after_rst99", 10, 8'h99, 1'b0, 1'b0);
        check_eq("final_valid_low", 32'(data_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
